// File: rtl/pingpong_wr_ctrl.sv
// pingpong_wr_ctrl: drains the read side of a FIFO into a two-bank ping-pong
// RAM in fixed-length bursts. It alternates banks, flags each bank to the
// downstream reader when full, and refills a bank only after the reader
// releases it. Backpressure is applied by withholding fifo_rd_en, so no data
// is ever dropped.
module pingpong_wr_ctrl #(
  parameter int DATA_W     = 14,
  parameter int BANK_DEPTH = 512,
  parameter int ADDR_W     = 9
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic              fifo_valid,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              ram_we,
  output logic              ram_bank,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic [1:0]        bank_ready,
  input  logic [1:0]        bank_release,
  output logic [ADDR_W:0]   fill_count
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(BANK_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BANK_DEPTH - 1);

  typedef enum logic [1:0] {
    S_FILL      = 2'd0,
    S_DRAIN     = 2'd1,
    S_WAIT_FREE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                cur_bank_q, cur_bank_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    fill_count_q, fill_count_d;
  logic [1:0]          bank_ready_q, bank_ready_d;
  logic                ram_we_q, ram_we_d;
  logic                ram_bank_q, ram_bank_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  // A FIFO word is accepted only if this controller asked for it last cycle.
  logic                rd_pend_q, rd_pend_d;
  // Low for the cycle following reset so no read is requested while in reset.
  logic                run_q, run_d;

  logic                rd_en;
  logic                accept;
  logic [1:0]          rel_ready;
  logic [1:0]          bank_set;

  // Next-state, read request and write-path computation.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    cur_bank_d   = cur_bank_q;
    issue_cnt_d  = issue_cnt_q;
    fill_count_d = fill_count_q;
    ram_we_d     = 1'b0;
    ram_bank_d   = ram_bank_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    bank_set     = 2'b00;
    run_d        = 1'b1;

    rd_en = run_q && (state_q == S_FILL) && !fifo_empty && (issue_cnt_q < DEPTH_CNT);
    rd_pend_d = rd_en;
    accept    = fifo_valid && rd_pend_q;

    if (rd_en) begin
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end

    // Register the popped word as a RAM write into the current bank.
    if (accept && (fill_count_q < DEPTH_CNT)) begin
      ram_we_d     = 1'b1;
      ram_din_d    = fifo_dout;
      ram_addr_d   = fill_count_q[ADDR_W-1:0];
      ram_bank_d   = cur_bank_q;
      fill_count_d = fill_count_q + CNT_W'(1);
    end

    // Releases clear ready bits in any state; clearing a clear bit is a no-op.
    rel_ready = bank_ready_q & ~bank_release;

    case (state_q)
      S_FILL: begin
        if (issue_cnt_d == DEPTH_CNT) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last word of the bank is on the RAM port this cycle.
        if (ram_we_q && (ram_addr_q == LAST_ADDR) && (ram_bank_q == cur_bank_q)) begin
          bank_set[cur_bank_q] = 1'b1;
          cur_bank_d   = ~cur_bank_q;
          issue_cnt_d  = '0;
          fill_count_d = '0;
          state_d      = rel_ready[~cur_bank_q] ? S_WAIT_FREE : S_FILL;
        end
      end
      S_WAIT_FREE: begin
        if (!rel_ready[cur_bank_q]) begin
          state_d = S_FILL;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase

    // A set on the same edge as a release of the same bank wins.
    bank_ready_d = rel_ready | bank_set;
  end

  // State register with synchronous reset.
  always_ff @(posedge sclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= S_FILL;
      cur_bank_q   <= 1'b0;
      issue_cnt_q  <= '0;
      fill_count_q <= '0;
      bank_ready_q <= 2'b00;
      ram_we_q     <= 1'b0;
      ram_bank_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      rd_pend_q    <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_bank_q   <= cur_bank_d;
      issue_cnt_q  <= issue_cnt_d;
      fill_count_q <= fill_count_d;
      bank_ready_q <= bank_ready_d;
      ram_we_q     <= ram_we_d;
      ram_bank_q   <= ram_bank_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      rd_pend_q    <= rd_pend_d;
      run_q        <= run_d;
    end
  end

  assign fifo_rd_en = rd_en;
  assign ram_we     = ram_we_q;
  assign ram_bank   = ram_bank_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign bank_ready = bank_ready_q;
  assign fill_count = fill_count_q;

endmodule

// File: tb/tb_pingpong_wr_ctrl.sv
// Testbench for pingpong_wr_ctrl with BANK_DEPTH=8. A behavioural FIFO feeds
// the DUT; every word loaded also pushes its expected RAM write (bank, addr,
// data) into a scoreboard queue that a negedge monitor pops on each ram_we.
module tb_pingpong_wr_ctrl;

  localparam int DATA_W     = 14;
  localparam int BANK_DEPTH = 8;
  localparam int ADDR_W     = 3;

  logic              sclk = 1'b0;
  logic              rst  = 1'b1;
  logic              fifo_empty;
  logic              fifo_valid = 1'b0;
  logic [DATA_W-1:0] fifo_dout  = '0;
  logic              fifo_rd_en;
  logic              ram_we;
  logic              ram_bank;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [1:0]        bank_ready;
  logic [1:0]        bank_release = 2'b00;
  logic [ADDR_W:0]   fill_count;

  typedef struct {
    int bank;
    int addr;
    int data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rd_cnt = 0;

  // FIFO model: storage written by stimulus, read pointer advanced on pops.
  int   mem [256];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic gate_empty = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr) || gate_empty;

  pingpong_wr_ctrl #(
    .DATA_W(DATA_W), .BANK_DEPTH(BANK_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .sclk(sclk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_valid(fifo_valid), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .ram_we(ram_we), .ram_bank(ram_bank), .ram_addr(ram_addr), .ram_din(ram_din),
    .bank_ready(bank_ready), .bank_release(bank_release), .fill_count(fill_count)
  );

  always #5 sclk = ~sclk;

  // One-cycle read latency FIFO.
  always @(posedge sclk) begin
    if (fifo_rd_en === 1'b1) begin
      fifo_dout  <= DATA_W'(mem[rd_ptr % 256]);
      rd_ptr     <= rd_ptr + 1;
      fifo_valid <= 1'b1;
    end else begin
      fifo_valid <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every RAM write must match the oldest expectation.
  always @(negedge sclk) begin
    if (fifo_rd_en === 1'b1) rd_cnt++;
    if (ram_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(ram_din), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_bank", 32'(ram_bank), 32'(e.bank));
        check("wr_addr", 32'(ram_addr), 32'(e.addr));
        check("wr_data", 32'(ram_din),  32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic push_word(input int data, input int bank, input int addr, input bit expect_wr);
    exp_t e;
    mem[wr_ptr % 256] = data;
    wr_ptr = wr_ptr + 1;
    if (expect_wr) begin
      e.bank = bank;
      e.addr = addr;
      e.data = data;
      sb.push_back(e);
    end
  endtask

  task automatic release_pulse(input logic [1:0] m);
    bank_release = m;
    tick();
    bank_release = 2'b00;
  endtask

  task automatic wait_ready(input logic [1:0] val, input string name);
    for (int i = 0; i < 200; i++) begin
      if (bank_ready == val) break;
      tick();
    end
    check(name, 32'(bank_ready), 32'(val));
  endtask

  task automatic wait_sb_empty(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    tick();
    check(name, 32'(sb.size()), 0);
  endtask

  initial begin
    int we7_cyc;
    int rdy_cyc;
    bit found;

    // 1. Reset held 3 cycles with a non-empty FIFO.
    for (int k = 0; k < 8; k++) push_word(1024 + k, 0, k, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_rd_en", 32'(fifo_rd_en), 0);
      check("rst_ram_we", 32'(ram_we), 0);
      check("rst_bank_ready", 32'(bank_ready), 0);
    end
    check("rst_fill_count", 32'(fill_count), 0);
    check("rst_ram_bank", 32'(ram_bank), 0);
    rst = 1'b0;
    tick();
    check("first_rd_en", 32'(fifo_rd_en), 1);

    // 2. Single bank: writes 0..7 of bank 0, ready one cycle after addr 7.
    we7_cyc = -1;
    rdy_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      if (ram_we && ram_addr == 3'd7 && we7_cyc < 0) we7_cyc = i;
      if (bank_ready == 2'b01) begin
        rdy_cyc = i;
        break;
      end
      tick();
    end
    check("t2_ready_delay", 32'(rdy_cyc - we7_cyc), 1);
    check("t2_bank_ready", 32'(bank_ready), 1);
    check("t2_rd_pulses", 32'(rd_cnt), 8);
    check("t2_fill_count", 32'(fill_count), 0);

    // 3. Backpressure: fill bank 1, then 4 words wait for bank 0 release.
    for (int k = 0; k < 8; k++) push_word(2000 + k, 1, k, 1'b1);
    for (int k = 0; k < 4; k++) push_word(3000 + k, 0, k, 1'b1);
    wait_ready(2'b11, "t3_both_ready");
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_rd_en_held", 32'(fifo_rd_en), 0);
    end
    check("t3_rd_pulses", 32'(rd_cnt), 16);
    check("t3_fill_count", 32'(fill_count), 0);
    release_pulse(2'b01);
    wait_sb_empty("t3_refill_done");
    check("t3_bank_ready", 32'(bank_ready), 2);
    check("t3_fill_count_after", 32'(fill_count), 4);
    check("t3_rd_pulses_after", 32'(rd_cnt), 20);

    // 5. Spurious releases leave ready bits and counters unchanged.
    release_pulse(2'b01);
    check("t5_rel0_ready", 32'(bank_ready), 2);
    check("t5_rel0_fill", 32'(fill_count), 4);
    release_pulse(2'b10);
    check("t5_legal_rel1", 32'(bank_ready), 0);
    release_pulse(2'b10);
    check("t5_rel1_ready", 32'(bank_ready), 0);
    check("t5_rel1_fill", 32'(fill_count), 4);
    check("t5_rd_en", 32'(fifo_rd_en), 0);

    // 4. Finish bank 0, then fill bank 1 with fifo_empty toggling every 3 cycles.
    for (int k = 0; k < 4; k++) push_word(5000 + k, 0, 4 + k, 1'b1);
    wait_ready(2'b01, "t4_bank0_ready");
    check("t4_fill_after_b0", 32'(fill_count), 0);
    for (int k = 0; k < 8; k++) push_word(6000 + k, 1, k, 1'b1);
    for (int i = 0; i < 120; i++) begin
      if (bank_ready == 2'b11) break;
      gate_empty = ((i / 3) % 2) == 0;
      tick();
    end
    gate_empty = 1'b0;
    check("t4_both_ready", 32'(bank_ready), 3);
    check("t4_fill_end", 32'(fill_count), 0);
    check("t4_rd_pulses", 32'(rd_cnt), 32);
    release_pulse(2'b11);
    check("t4_release_both", 32'(bank_ready), 0);
    tick();

    // 6. Reset after 5 writes to bank 0; in-flight word is dropped.
    for (int k = 0; k < 8; k++) push_word(4000 + k, 0, k, k < 5);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ram_we && ram_addr == 3'd4) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_fifth_write", 32'(found), 1);
    rst = 1'b1;
    tick();
    check("t6_fill_count", 32'(fill_count), 0);
    check("t6_ram_bank", 32'(ram_bank), 0);
    check("t6_bank_ready", 32'(bank_ready), 0);
    check("t6_ram_we", 32'(ram_we), 0);
    tick();
    check("t6_ram_we_inflight", 32'(ram_we), 0);
    // Words 6 and 7 were popped before/at reset; word 8 is still queued.
    begin
      exp_t e;
      e.bank = 0;
      e.addr = 0;
      e.data = 4007;
      sb.push_back(e);
    end
    rst = 1'b0;
    wait_sb_empty("t6_resume_done");
    check("t6_fill_after", 32'(fill_count), 1);
    check("t6_ready_after", 32'(bank_ready), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
